// File: rtl/bcd_display_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_display_ctrl
//
// Sequential binary-to-BCD converter and display-register controller for the
// six-digit seven-segment decoder stage. A start pulse in IDLE captures bin_in
// and dp_pos. A shift-add-3 (double-dabble) sequencer then converts the value
// at one bit per clock. The finished BCD word, decimal-point mask and overflow
// flag are committed together to held output registers, so the display never
// sees a partially converted value.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   -> blank_mask marks leading-zero digits left of the decimal point
//   undefined -> blank_mask is tied to zero and no blanking logic exists
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   reset      in   asynchronous active-high reset
//   start      in   single-cycle convert request, honoured only in IDLE
//   bin_in     in   [BIN_WIDTH-1:0] unsigned value, sampled with start
//   dp_pos     in   [2:0] decimal-point digit index (0 = rightmost)
//   busy       out  high while a conversion is in flight (SHIFT and COMMIT)
//   done       out  one-cycle pulse when new outputs are committed
//   bcd_out    out  [4*DIGITS-1:0] packed BCD, digit i at [4i+3:4i]
//   dp_mask    out  [DIGITS-1:0] one-hot decimal point, 0 if dp_pos >= DIGITS
//   overflow   out  committed value was saturated to all nines
//   blank_mask out  [DIGITS-1:0] leading-zero blank enables
// -----------------------------------------------------------------------------
module bcd_display_ctrl #(
   parameter int BIN_WIDTH = 20,
   parameter int DIGITS    = 6,
   parameter int MAX_VAL   = 999999
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [BIN_WIDTH-1:0]  bin_in,
   input  logic [2:0]            dp_pos,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     dp_mask,
   output logic                  overflow,
   output logic [DIGITS-1:0]     blank_mask
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);
   localparam logic [BIN_WIDTH:0] MAX_VEC = (BIN_WIDTH + 1)'(MAX_VAL);

   typedef enum logic [1:0] {
      st_idle,
      st_shift,
      st_commit
   } state_t;

   state_t               state_reg;
   logic [BIN_WIDTH-1:0] bin_reg;
   logic [BCD_W-1:0]     scratch_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic [2:0]           dp_reg;
   logic                 sat_reg;

   logic                 busy_reg;
   logic                 done_reg;
   logic [BCD_W-1:0]     bcd_reg;
   logic [DIGITS-1:0]    dp_mask_reg;
   logic                 overflow_reg;

   logic [BCD_W-1:0]     adj;
   logic [BCD_W-1:0]     nines;
   logic [BCD_W-1:0]     scratch_next;
   logic [BIN_WIDTH-1:0] bin_next;
   logic [DIGITS-1:0]    dp_onehot;
   logic                 sat_next;

   // Compare with one extra bit so MAX_VAL is never truncated against bin_in.
   assign sat_next = ({1'b0, bin_in} > MAX_VEC);

   // Per-nibble add-3 correction, a saturation constant, and the decimal-point
   // decode. Every digit index below DIGITS is decoded, so dp_pos values of
   // DIGITS or more give an all-zero mask.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign adj[4*gi +: 4]   = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                                   scratch_reg[4*gi +: 4] + 4'd3 :
                                   scratch_reg[4*gi +: 4];
         assign nines[4*gi +: 4] = 4'd9;
         assign dp_onehot[gi]    = (32'(dp_reg) == gi);
      end
   endgenerate

   // Shift {scratch, binary} left by one. The top scratch bit falls off; that
   // only happens for saturated inputs, whose result is overridden anyway.
   assign scratch_next = BCD_W'({adj, bin_reg[BIN_WIDTH-1]});
   assign bin_next     = {bin_reg[BIN_WIDTH-2:0], 1'b0};

`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_reg;
   logic [DIGITS-1:0] blank_next;

   // A digit blanks when it and every digit above it are zero and it lies left
   // of the decimal point. With no decimal point shown, every leading zero
   // blanks except the units digit.
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_blank
         if (gi == 0) begin : g_units
            assign blank_next[gi] = 1'b0;
         end else begin : g_upper
            assign blank_next[gi] = (scratch_next[BCD_W-1:4*gi] == '0) &&
                                    ((32'(dp_reg) >= DIGITS) ||
                                     (gi > 32'(dp_reg)));
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blank_reg <= '0;
      end else if (state_reg == st_shift && cnt_reg == CNT_W'(1)) begin
         blank_reg <= sat_reg ? '0 : blank_next;
      end
   end

   assign blank_mask = blank_reg;
`else
   assign blank_mask = '0;
`endif

   // Sequencer. Outputs are committed on the edge that ends the last shift
   // cycle, so bcd_out, dp_mask and overflow are valid in the same cycle done
   // is high. They hold their value for the rest of the time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= st_idle;
         bin_reg      <= '0;
         scratch_reg  <= '0;
         cnt_reg      <= '0;
         dp_reg       <= '0;
         sat_reg      <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         bcd_reg      <= '0;
         dp_mask_reg  <= '0;
         overflow_reg <= 1'b0;
      end else begin
         case (state_reg)
            st_idle: begin
               done_reg <= 1'b0;
               if (start) begin
                  bin_reg     <= bin_in;
                  dp_reg      <= dp_pos;
                  sat_reg     <= sat_next;
                  scratch_reg <= '0;
                  cnt_reg     <= CNT_W'(BIN_WIDTH);
                  busy_reg    <= 1'b1;
                  state_reg   <= st_shift;
               end
            end
            st_shift: begin
               scratch_reg <= scratch_next;
               bin_reg     <= bin_next;
               cnt_reg     <= cnt_reg - CNT_W'(1);
               if (cnt_reg == CNT_W'(1)) begin
                  bcd_reg      <= sat_reg ? nines : scratch_next;
                  overflow_reg <= sat_reg;
                  dp_mask_reg  <= dp_onehot;
                  done_reg     <= 1'b1;
                  state_reg    <= st_commit;
               end
            end
            st_commit: begin
               // Any start seen here is dropped, not queued.
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= st_idle;
            end
            default: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= st_idle;
            end
         endcase
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign bcd_out  = bcd_reg;
   assign dp_mask  = dp_mask_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_ctrl
//
// Drives directed and random conversions into bcd_display_ctrl and compares
// each committed result with a decimal reference built from division and
// modulo. Also checks latency, busy framing, output hold, ignored starts,
// and a reset during a conversion.
// -----------------------------------------------------------------------------
module tb_bcd_display_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [19:0] bin_in;
   logic [2:0]  dp_pos;
   logic        busy;
   logic        done;
   logic [23:0] bcd_out;
   logic [5:0]  dp_mask;
   logic        overflow;
   logic [5:0]  blank_mask;

   int pass_cnt  = 0;
   int check_cnt = 0;

   logic [23:0] exp_bcd;
   logic [5:0]  exp_dp;
   logic        exp_ov;
   logic [5:0]  exp_blank;

   bcd_display_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bin_in     (bin_in),
      .dp_pos     (dp_pos),
      .busy       (busy),
      .done       (done),
      .bcd_out    (bcd_out),
      .dp_mask    (dp_mask),
      .overflow   (overflow),
      .blank_mask (blank_mask)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      check_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Decimal digits of the value, clamped to 999999.
   function automatic logic [23:0] ref_bcd(input int unsigned v);
      logic [23:0] r;
      int unsigned p;
      if (v > 999999) v = 999999;
      p = 1;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // Digit i is a leading zero when v < 10^i.
   function automatic logic [5:0] ref_blank(input int unsigned v, input int dp);
      logic [5:0] b;
      int unsigned p;
      b = '0;
      if (v > 999999) return b;
      p = 10;
      for (int i = 1; i < 6; i++) begin
         if (v < p && (dp >= 6 || i > dp)) b[i] = 1'b1;
         p = p * 10;
      end
      return b;
   endfunction

   // One conversion: start presented now, accepted at the next edge (cycle 0).
   // Optionally raises a second start in cycle extra_at while busy.
   task automatic run_conv(input int unsigned v, input int dp, input int extra_at);
      logic [23:0] pb;
      logic [5:0]  pd;
      logic        po;
      int          done_cyc;
      int          busy_err;
      int          hold_err;
      pb = exp_bcd;
      pd = exp_dp;
      po = exp_ov;
      done_cyc = 0;
      busy_err = 0;
      hold_err = 0;
      bin_in = v[19:0];
      dp_pos = dp[2:0];
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (done) begin
            done_cyc = c;
            if (!busy) busy_err++;
            break;
         end
         if (!busy) busy_err++;
         if ({bcd_out, dp_mask, overflow} !== {pb, pd, po}) hold_err++;
         if (c == extra_at) begin
            start  = 1'b1;
            bin_in = 20'd222222;
            dp_pos = 3'd0;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;

      exp_bcd = ref_bcd(v);
      exp_ov  = (v > 999999);
      exp_dp  = (dp < 6) ? 6'(1 << dp) : 6'd0;
`ifdef LEADING_ZERO_BLANK_EN
      exp_blank = ref_blank(v, dp);
`else
      exp_blank = 6'd0;
`endif
      $display("conv bin=%0d dp=%0d -> bcd=%h dp_mask=%b ovf=%0d blank=%b done_cyc=%0d",
               v, dp, bcd_out, dp_mask, overflow, blank_mask, done_cyc);
      check("done_cycle", done_cyc, 21);
      check("busy_frame", busy_err, 0);
      check("hold_prior", hold_err, 0);
      check("bcd_out", bcd_out, exp_bcd);
      check("dp_mask", dp_mask, exp_dp);
      check("overflow", overflow, exp_ov);
      check("blank_mask", blank_mask, exp_blank);

      // Cycle after done: back to idle, outputs still held.
      @(posedge clk); #1;
      check("idle_after", {busy, done}, 2'b00);
      check("held_after", {bcd_out, dp_mask, overflow, blank_mask},
            {exp_bcd, exp_dp, exp_ov, exp_blank});
   endtask

   initial begin
      int unsigned v;
      int          dp;
      int          ndone;

      reset  = 1'b1;
      start  = 1'b0;
      bin_in = '0;
      dp_pos = '0;
      exp_bcd = '0;
      exp_dp = '0;
      exp_ov = 1'b0;
      exp_blank = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {busy, done, bcd_out, dp_mask, overflow, blank_mask}, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("idle_state", {busy, done}, 2'b00);

      run_conv(123456, 3, 0);
      run_conv(0, 0, 0);
      run_conv(999999, 5, 0);
      run_conv(1048575, 1, 0);
      run_conv(42, 0, 0);
      run_conv(111111, 2, 5);
      run_conv(42, 7, 0);
      run_conv(42, 2, 0);
      run_conv(1000000, 6, 0);

      // Reset in cycle 10 of a conversion.
      bin_in = 20'd654321;
      dp_pos = 3'd1;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("reset_mid", {busy, done, bcd_out, dp_mask, overflow, blank_mask}, 0);
      $display("reset mid-conversion -> busy=%0d done=%0d bcd=%h", busy, done, bcd_out);
      exp_bcd = '0;
      exp_dp = '0;
      exp_ov = 1'b0;
      exp_blank = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      ndone = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      check("no_done_after_reset", ndone, 0);
      run_conv(314159, 4, 0);

      for (int n = 0; n < 20; n++) begin
         case ($urandom_range(0, 3))
            0:       v = $urandom_range(0, 99);
            1:       v = $urandom_range(999000, 1048575);
            default: v = $urandom_range(0, 1048575);
         endcase
         dp = int'($urandom_range(0, 7));
         run_conv(v, dp, (n % 4 == 0) ? int'($urandom_range(1, 20)) : 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
